// File: rtl/spi_register_access_if.sv
// axis_interface: byte-wide AXI-stream bundle that connects spi_register_access
// to spi_master.
//   tdata  [7:0]  payload byte
//   tkeep  [0:0]  byte enable (always 1 on this link)
//   tlast         end of frame
//   tvalid/tready handshake
//   tid/tdest/tuser  sideband, driven 0 by the source
// Modports: master = stream source, slave = stream sink.
interface axis_interface;
    logic [7:0] tdata;
    logic [0:0] tkeep;
    logic       tlast;
    logic       tvalid;
    logic       tready;
    logic [0:0] tid;
    logic [0:0] tdest;
    logic [0:0] tuser;

    modport master (
        output tdata, tkeep, tlast, tvalid, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/spi_register_access.sv
// spi_register_access: register-transaction front end for spi_master.
// Takes one read/write command, sends it as a byte frame (header {~write, addr}
// followed by DATA_BYTES payload bytes, MSB byte first) on mosi_stream, collects
// the bytes spi_master returns on miso_stream and presents one response.
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_write, cmd_addr, cmd_wdata  command fields
//   rsp_valid/rsp_ready           response handshake, response held until taken
//   rsp_write, rsp_rdata, rsp_error  write echo, returned payload, timeout flag
//   mosi_stream (master)          bytes to spi_master
//   miso_stream (slave)           bytes from spi_master
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// SEND    | driving frame bytes on mosi_stream, capturing returned bytes
// DRAIN   | timed out with a MOSI beat still offered; finish that beat
// WAIT_RX | whole frame sent, waiting for the remaining MISO bytes
// RESPOND | response presented until rsp_ready
module spi_register_access #(
    parameter int         DATA_BYTES     = 2,
    parameter logic [7:0] DUMMY_BYTE     = 8'hFF,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [6:0]              cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    rsp_error,
    axis_interface.master           mosi_stream,
    axis_interface.slave            miso_stream
);

    localparam int              DW         = 8 * DATA_BYTES;
    localparam int              TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0]      FRAME      = 3'(DATA_BYTES + 1);
    localparam logic [2:0]      LAST_TX    = 3'(DATA_BYTES);
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        DRAIN,
        WAIT_RX,
        RESPOND
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            wr_q;
    logic [6:0]      addr_q;
    logic [DW-1:0]   wdata_q;
    logic [2:0]      tx_idx;
    logic [2:0]      rx_idx;
    logic [TW-1:0]   timer_left;
    logic [DW-1:0]   rdata_q;
    logic            error_q;

    logic            mosi_hs;
    logic            miso_hs;
    logic            rx_active;
    logic            rx_take;
    logic            rx_done;
    logic            counting;
    logic            timed_out;
    logic            tx_last;
    logic            mosi_valid;
    logic            miso_ready;
    logic [7:0]      tx_byte;
    logic [2:0]      rx_idx_next;

    assign mosi_hs   = mosi_valid && mosi_stream.tready;
    assign miso_hs   = miso_stream.tvalid && miso_ready;
    assign rx_active = (state == SEND) || (state == WAIT_RX);
    // Bytes past the end of the frame, or outside SEND/WAIT_RX, are dropped.
    assign rx_take     = rx_active && miso_hs && (rx_idx < FRAME);
    assign rx_idx_next = rx_take ? rx_idx + 3'd1 : rx_idx;
    assign rx_done     = (rx_idx_next == FRAME);
    assign tx_last     = (tx_idx == LAST_TX);
    // Watchdog only runs while returned bytes are owed and none arrives.
    assign counting    = rx_active && (rx_idx < tx_idx) && !miso_hs;
    assign timed_out   = counting && (timer_left == '0);

    always_comb begin
        tx_byte = {~wr_q, addr_q};
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (tx_idx == 3'(b + 1)) begin
                tx_byte = wr_q ? wdata_q[8*(DATA_BYTES-1-b) +: 8] : DUMMY_BYTE;
            end
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        mosi_valid = 1'b0;
        miso_ready = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = SEND;
            end
            SEND: begin
                mosi_valid = 1'b1;
                if (timed_out) begin
                    // Never pull tvalid back while a beat is still being offered.
                    state_next = mosi_hs ? RESPOND : DRAIN;
                end else if (mosi_hs && tx_last) begin
                    state_next = rx_done ? RESPOND : WAIT_RX;
                end
            end
            DRAIN: begin
                mosi_valid = 1'b1;
                if (mosi_hs) state_next = RESPOND;
            end
            WAIT_RX: begin
                if (timed_out || rx_done) state_next = RESPOND;
            end
            RESPOND: begin
                miso_ready = 1'b0;
                rsp_valid  = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_idx     <= '0;
            rx_idx     <= '0;
            timer_left <= TIMER_LOAD;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE && cmd_valid) begin
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                tx_idx  <= '0;
                rx_idx  <= '0;
                rdata_q <= '0;
                error_q <= 1'b0;
            end

            if (mosi_hs) tx_idx <= tx_idx + 3'd1;

            if (rx_take) begin
                rx_idx <= rx_idx + 3'd1;
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (rx_idx == 3'(b + 1)) begin
                        rdata_q[8*(DATA_BYTES-1-b) +: 8] <= miso_stream.tdata;
                    end
                end
            end

            // Down-counter: TIMER_LOAD means no idle cycles seen yet.
            if (counting && timer_left != '0) begin
                timer_left <= timer_left - 1'b1;
            end else begin
                timer_left <= TIMER_LOAD;
            end

            if (timed_out) error_q <= 1'b1;
        end
    end

    assign mosi_stream.tvalid = mosi_valid;
    assign mosi_stream.tdata  = tx_byte;
    assign mosi_stream.tlast  = mosi_valid && tx_last;
    assign mosi_stream.tkeep  = 1'b1;
    assign mosi_stream.tid    = 1'b0;
    assign mosi_stream.tdest  = 1'b0;
    assign mosi_stream.tuser  = 1'b0;
    assign miso_stream.tready = miso_ready;

    assign rsp_write = wr_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_spi_register_access.sv
// Testbench for spi_register_access: loopback byte stub in place of spi_master
// (returns every MOSI byte on MISO, or only the header byte in fault mode),
// scoreboard queues filled at command issue, and a monitor that checks every
// MOSI beat and every response against them.
module tb_spi_register_access;

    localparam int NORMAL   = 0;
    localparam int HDR_ONLY = 1;

    typedef struct {
        logic        w;
        logic [15:0] d;
        logic        e;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [15:0] rsp_rdata;
    logic        rsp_error;

    axis_interface mosi_if ();
    axis_interface miso_if ();

    spi_register_access #(
        .DATA_BYTES     (2),
        .DUMMY_BYTE     (8'hFF),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .mosi_stream (mosi_if),
        .miso_stream (miso_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [8:0] exp_mosi[$];
    rsp_t       exp_rsp[$];

    int stub_mode  = NORMAL;
    bit full_rate  = 1'b1;
    bit stall_req  = 1'b0;
    int rsp_hold   = 0;
    int mosi_beats = 0;
    int rsp_count  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Byte-level spi_master stand-in: loops MOSI bytes back on MISO.
    initial begin : stub
        logic [7:0] loop_q[$];
        bit         p_mosi;
        bit         p_miso;
        logic [7:0] p_data;
        logic       p_last;
        int         fpos;
        int         delay;
        int         stall_left;
        p_mosi = 0; p_miso = 0; p_data = '0; p_last = 0;
        fpos = 0; delay = 0; stall_left = 0;
        mosi_if.tready = 1'b0;
        miso_if.tvalid = 1'b0;
        miso_if.tdata  = '0;
        miso_if.tkeep  = 1'b1;
        miso_if.tlast  = 1'b0;
        miso_if.tid    = 1'b0;
        miso_if.tdest  = 1'b0;
        miso_if.tuser  = 1'b0;
        rsp_ready      = 1'b0;
        forever begin
            @(negedge clk);
            if (p_mosi) begin
                if (stub_mode == NORMAL || fpos == 0) loop_q.push_back(p_data);
                fpos = p_last ? 0 : fpos + 1;
                if (stall_req && fpos == 1) begin
                    stall_left = 20;
                    stall_req  = 1'b0;
                end
            end
            if (p_miso) begin
                void'(loop_q.pop_front());
                delay = full_rate ? 0 : int'($urandom_range(0, 2));
            end
            if (stall_left > 0) begin
                mosi_if.tready = 1'b0;
                stall_left--;
            end else begin
                mosi_if.tready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            if (delay > 0) begin
                miso_if.tvalid = 1'b0;
                delay--;
            end else if (loop_q.size() > 0) begin
                miso_if.tvalid = 1'b1;
                miso_if.tdata  = loop_q[0];
            end else begin
                miso_if.tvalid = 1'b0;
            end
            if (rsp_hold > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) rsp_hold--;
            end else begin
                rsp_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            #1;
            if (reset) begin
                loop_q.delete();
                fpos  = 0;
                delay = 0;
            end
            p_mosi = mosi_if.tvalid && mosi_if.tready && !reset;
            p_data = mosi_if.tdata;
            p_last = mosi_if.tlast;
            p_miso = miso_if.tvalid && miso_if.tready && !reset;
        end
    end

    // Monitor: samples just after the falling edge, judging the handshakes that
    // the next rising edge will complete.
    initial begin : monitor
        bit         prev_stall = 0;
        bit         prev_rsp_stall = 0;
        bit         prev_rsp_valid = 0;
        bit         chk_cmd_ready = 0;
        logic [8:0] hold_beat = '0;
        logic [18:0] hold_rsp = '0;
        logic [8:0] b;
        rsp_t       r;
        int         sample_idx = 0;
        int         last_miso = 0;
        int         diff;
        forever begin
            @(negedge clk);
            #1;
            sample_idx++;
            if (reset) begin
                prev_stall     = 0;
                prev_rsp_stall = 0;
                prev_rsp_valid = 0;
                chk_cmd_ready  = 0;
                continue;
            end
            if (prev_stall) begin
                check("mosi_hold_valid", mosi_if.tvalid, 1);
                check("mosi_hold_beat", {mosi_if.tlast, mosi_if.tdata}, hold_beat);
            end
            if (mosi_if.tvalid && mosi_if.tready) begin
                mosi_beats++;
                check("mosi_sideband", {mosi_if.tkeep, mosi_if.tid, mosi_if.tdest, mosi_if.tuser}, 4'b1000);
                if (exp_mosi.size() == 0) begin
                    checks++;
                    $display("FAIL mosi_unexpected: got beat %0h required no beat", {mosi_if.tlast, mosi_if.tdata});
                end else begin
                    b = exp_mosi.pop_front();
                    check("mosi_beat", {mosi_if.tlast, mosi_if.tdata}, b);
                end
            end
            prev_stall = mosi_if.tvalid && !mosi_if.tready;
            hold_beat  = {mosi_if.tlast, mosi_if.tdata};

            if (chk_cmd_ready) check("cmd_ready_after_rsp", cmd_ready, 1);
            chk_cmd_ready = 0;
            if (prev_rsp_stall)
                check("rsp_hold", {rsp_valid, rsp_write, rsp_error, rsp_rdata}, hold_rsp);
            if (rsp_valid && !prev_rsp_valid && exp_rsp.size() > 0) begin
                diff = sample_idx - last_miso;
                if (!exp_rsp[0].e) check("rsp_latency", diff, 1);
                else check("timeout_latency_le17", (diff >= 2 && diff <= 17), 1);
            end
            if (rsp_valid) begin
                check("cmd_ready_busy", cmd_ready, 0);
                if (rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        $display("FAIL rsp_unexpected: got rdata %0h required no response", rsp_rdata);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_write", rsp_write, r.w);
                        check("rsp_rdata", rsp_rdata, r.d);
                        check("rsp_error", rsp_error, r.e);
                    end
                    rsp_count++;
                    chk_cmd_ready = 1;
                end
            end
            prev_rsp_stall = rsp_valid && !rsp_ready;
            hold_rsp       = {rsp_valid, rsp_write, rsp_error, rsp_rdata};
            prev_rsp_valid = rsp_valid;
            if (miso_if.tvalid && miso_if.tready) last_miso = sample_idx;
        end
    end

    // Reference model: frame bytes and loopback response from the command alone.
    task automatic issue(input bit w, input logic [6:0] a, input logic [15:0] d, input int mode);
        int   n = 0;
        rsp_t r;
        logic [7:0] p1;
        logic [7:0] p0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        stub_mode = mode;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        p1 = w ? d[15:8] : 8'hFF;
        p0 = w ? d[7:0]  : 8'hFF;
        exp_mosi.push_back({1'b0, ~w, a});
        exp_mosi.push_back({1'b0, p1});
        exp_mosi.push_back({1'b1, p0});
        r.w = w;
        r.e = (mode == HDR_ONLY);
        r.d = (mode == HDR_ONLY) ? 16'h0000 : {p1, p0};
        exp_rsp.push_back(r);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = 16'($urandom);
        check("mosi_first_latency", mosi_if.tvalid, 1);
        check("cmd_ready_after_accept", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input int start);
        int n = 0;
        while (rsp_count == start && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrived", (rsp_count != start), 1);
    endtask

    initial begin : main
        int base;
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_error", rsp_error, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_mosi_tvalid", mosi_if.tvalid, 0);
        check("reset_mosi_tlast", mosi_if.tlast, 0);
        reset = 1'b0;

        full_rate = 1'b1;
        issue(1'b1, 7'h12, 16'hA5C3, NORMAL);
        wait_rsp(rsp_count - 0 - ((exp_rsp.size() == 0) ? 1 : 0));
        base = rsp_count;
        issue(1'b0, 7'h12, 16'h0000, NORMAL);
        wait_rsp(base);

        base = rsp_count;
        stall_req = 1'b1;
        issue(1'b1, 7'h34, 16'h1234, NORMAL);
        wait_rsp(base);

        base = rsp_count;
        issue(1'b0, 7'h05, 16'h0000, HDR_ONLY);
        wait_rsp(base);
        base = rsp_count;
        issue(1'b0, 7'h06, 16'h0000, NORMAL);
        wait_rsp(base);

        base = rsp_count;
        rsp_hold = 10;
        issue(1'b1, 7'h7F, 16'h5A0F, NORMAL);
        wait_rsp(base);

        base = mosi_beats;
        issue(1'b1, 7'h21, 16'hBEEF, NORMAL);
        n = 0;
        while (mosi_beats < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_two_beats", (mosi_beats >= base + 2), 1);
        reset = 1'b1;
        exp_mosi.delete();
        exp_rsp.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midreset_tvalid", mosi_if.tvalid, 0);
        check("midreset_cmd_ready", cmd_ready, 1);
        check("midreset_rsp_valid", rsp_valid, 0);
        repeat (6) @(negedge clk);
        check("midreset_no_rsp", rsp_valid, 0);
        base = rsp_count;
        issue(1'b1, 7'h22, 16'hC0DE, NORMAL);
        wait_rsp(base);

        full_rate = 1'b0;
        for (int i = 0; i < 25; i++) begin
            base = rsp_count;
            issue(1'($urandom), 7'($urandom), 16'($urandom), NORMAL);
            wait_rsp(base);
        end

        full_rate = 1'b1;
        repeat (5) @(negedge clk);
        check("final_exp_mosi_empty", exp_mosi.size(), 0);
        check("final_exp_rsp_empty", exp_rsp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
